// File: rtl/loop_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loop_pkg
//  Brief    : Shared definitions for the loop sequencer family (ascending and
//             descending): FSM state encoding and the default index width.
//  Revision : 1.0 - initial release
// ============================================================================
package loop_pkg;

    // Default index width for loop counters
    localparam int c_idx_w = 8;

    // Loop sequencer states, 2-bit encoding shared by both loop FSMs
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : loop_pkg
`default_nettype wire

// File: rtl/loop_down_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : loop_down_cnt
//  Brief    : Loadable down-counter with zero flag. Load has priority over
//             decrement; decrementing at zero holds zero (never wraps).
//  Revision : 1.0 - initial release
// ============================================================================
module loop_down_cnt
    import loop_pkg::*;
#(
    parameter int IDX_W  = c_idx_w,
    parameter int RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    output logic [IDX_W-1:0] o_cnt,
    output logic             o_zero
);

    localparam logic [IDX_W-1:0] c_reload = IDX_W'(RELOAD);
    localparam logic [IDX_W-1:0] c_one    = IDX_W'(1);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    // Next count: reload wins, otherwise step down but never below zero
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = c_reload;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_one;
        end
    end

    // Count register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_zero = (cnt_q == '0);

endmodule : loop_down_cnt
`default_nettype wire

// File: rtl/nested_loop_rev.sv
`default_nettype none
// ============================================================================
//  Module   : nested_loop_rev
//  Brief    : Descending nested-loop sequencer. On start walks i from
//             OUTER_N-1 to 0 and, per i, j from INNER_N-1 to 0, handing one
//             (i,j) pair per valid/ready transfer downstream; raises a sticky
//             finish once (0,0) has been accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module nested_loop_rev
    import loop_pkg::*;
#(
    parameter int OUTER_N = 2,
    parameter int INNER_N = 2,
    parameter int IDX_W   = c_idx_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] idx_j,
    output logic             busy,
    output logic             finish
);

    // A zero trip count on either loop means the body never runs
    localparam bit c_empty     = (OUTER_N == 0) || (INNER_N == 0);
    localparam int c_outer_rld = (OUTER_N == 0) ? 0 : OUTER_N - 1;
    localparam int c_inner_rld = (INNER_N == 0) ? 0 : INNER_N - 1;

    state_t state_q, state_d;
    logic   valid_q, valid_d;
    logic   busy_q, busy_d;
    logic   finish_q, finish_d;

    logic   w_xfer;
    logic   w_ld_o, w_ld_i;
    logic   w_dec_o, w_dec_i;
    logic   w_i_zero, w_j_zero;

    // Outer index counter; its register is the idx_i output register
    loop_down_cnt #(
        .IDX_W  (IDX_W),
        .RELOAD (c_outer_rld)
    ) u_outer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ld_o),
        .i_dec  (w_dec_o),
        .o_cnt  (idx_i),
        .o_zero (w_i_zero)
    );

    // Inner index counter; reloaded on launch and on every outer step
    loop_down_cnt #(
        .IDX_W  (IDX_W),
        .RELOAD (c_inner_rld)
    ) u_inner (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ld_i),
        .i_dec  (w_dec_i),
        .o_cnt  (idx_j),
        .o_zero (w_j_zero)
    );

    assign w_xfer = valid_q & idx_ready;

    // Next-state, next-output and counter control decode
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        w_ld_o   = 1'b0;
        w_ld_i   = 1'b0;
        w_dec_o  = 1'b0;
        w_dec_i  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (c_empty) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                    end else begin
                        w_ld_o   = 1'b1;
                        w_ld_i   = 1'b1;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        finish_d = 1'b0;
                        state_d  = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    if (!w_j_zero) begin
                        w_dec_i = 1'b1;
                    end else if (!w_i_zero) begin
                        w_dec_o = 1'b1;
                        w_ld_i  = 1'b1;
                    end else begin
                        valid_d  = 1'b0;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                finish_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign idx_valid = valid_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule : nested_loop_rev
`default_nettype wire

// File: tb/tb_nested_loop_rev.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nested_loop_rev
//  Brief    : Scoreboard bench for nested_loop_rev. Three instances: 2x2
//             (main), 0x2 (empty loop) and 3x1 (tall). Expected pair streams
//             are generated from plain nested loops and consumed by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nested_loop_rev;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic       start     = 1'b0;
    logic       idx_ready = 1'b1;
    logic       idx_valid, busy, finish;
    logic [7:0] idx_i, idx_j;

    logic       e_start = 1'b0;
    logic       e_ready = 1'b1;
    logic       e_valid, e_busy, e_finish;
    logic [7:0] e_i, e_j;

    logic       t_start = 1'b0;
    logic       t_ready = 1'b1;
    logic       t_valid, t_busy, t_finish;
    logic [7:0] t_i, t_j;

    nested_loop_rev #(.OUTER_N(2), .INNER_N(2), .IDX_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .idx_ready(idx_ready),
        .idx_valid(idx_valid), .idx_i(idx_i), .idx_j(idx_j),
        .busy(busy), .finish(finish)
    );

    nested_loop_rev #(.OUTER_N(0), .INNER_N(2), .IDX_W(8)) u_empty (
        .clk(clk), .rst(rst), .start(e_start), .idx_ready(e_ready),
        .idx_valid(e_valid), .idx_i(e_i), .idx_j(e_j),
        .busy(e_busy), .finish(e_finish)
    );

    nested_loop_rev #(.OUTER_N(3), .INNER_N(1), .IDX_W(8)) u_tall (
        .clk(clk), .rst(rst), .start(t_start), .idx_ready(t_ready),
        .idx_valid(t_valid), .idx_i(t_i), .idx_j(t_j),
        .busy(t_busy), .finish(t_finish)
    );

    // Index 0 = main 2x2 instance, index 1 = tall 3x1 instance
    logic        vld [2];
    logic        rdy [2];
    logic        fin [2];
    logic        bsy [2];
    logic [15:0] pr  [2];
    assign vld[0] = idx_valid;  assign vld[1] = t_valid;
    assign rdy[0] = idx_ready;  assign rdy[1] = t_ready;
    assign fin[0] = finish;     assign fin[1] = t_finish;
    assign bsy[0] = busy;       assign bsy[1] = t_busy;
    assign pr[0]  = {idx_i, idx_j};
    assign pr[1]  = {t_i, t_j};

    logic [15:0] exp_q [2][$];
    bit          fin_pend [2];
    bit          hold_v   [2];
    logic [15:0] held     [2];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the full descending pair stream of one launch
    task automatic push_run(input int d, input int on, input int inn);
        for (int i = on - 1; i >= 0; i--)
            for (int j = inn - 1; j >= 0; j--)
                exp_q[d].push_back({8'(i), 8'(j)});
    endtask

    // Pulse start for one cycle; a launch only happens when no run is pending
    task automatic launch(input int d);
        @(posedge clk); #1;
        if (exp_q[d].size() == 0) begin
            if (d == 0) push_run(0, 2, 2);
            else        push_run(1, 3, 1);
        end
        if (d == 0) start = 1'b1; else t_start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = 1'b0;
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n = 0;
        while ((exp_q[d].size() != 0 || fin_pend[d]) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q[d].size() != 0 || fin_pend[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: dut %0d still has %0d pairs outstanding", d, exp_q[d].size());
            exp_q[d].delete();
            fin_pend[d] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Ready driver: always-on, 1,0,0 pattern, or random
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       begin idx_ready = 1'b1; t_ready = 1'b1; end
                1:       begin idx_ready = (cyc % 3 == 0); t_ready = idx_ready; end
                default: begin idx_ready = 1'($urandom_range(0, 1)); t_ready = 1'($urandom_range(0, 1)); end
            endcase
            cyc++;
        end
    end

    // Monitor: pops expected pairs on each transfer, checks hold and finish
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    hold_v[d]   = 1'b0;
                    fin_pend[d] = 1'b0;
                end else begin
                    if (fin_pend[d]) begin
                        chk("finish_after_last", {29'd0, fin[d], bsy[d], vld[d]}, 32'd4);
                        fin_pend[d] = 1'b0;
                    end
                    if (!vld[d]) begin
                        hold_v[d] = 1'b0;
                    end else begin
                        if (hold_v[d]) chk("pair_hold", {16'd0, pr[d]}, {16'd0, held[d]});
                        chk("busy_with_valid", {31'd0, bsy[d]}, 32'd1);
                        if (rdy[d]) begin
                            hold_v[d] = 1'b0;
                            if (exp_q[d].size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL extra_xfer: dut %0d pair 0x%0h with nothing expected", d, pr[d]);
                            end else begin
                                chk("pair", {16'd0, pr[d]}, {16'd0, exp_q[d].pop_front()});
                                if (exp_q[d].size() == 0) fin_pend[d] = 1'b1;
                            end
                        end else begin
                            hold_v[d] = 1'b1;
                            held[d]   = pr[d];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_main",  {13'd0, idx_valid, busy, finish, idx_i, idx_j}, 32'd0);
        chk("rst_empty", {13'd0, e_valid, e_busy, e_finish, e_i, e_j}, 32'd0);
        chk("rst_tall",  {13'd0, t_valid, t_busy, t_finish, t_i, t_j}, 32'd0);
        rst = 1'b0;

        // Back-to-back run: (1,1) right after start, finish 4 cycles later
        rdy_mode = 0;
        launch(0);
        chk("first_pair", {13'd0, idx_valid, busy, finish, idx_i, idx_j}, {13'd0, 3'b110, 8'd1, 8'd1});
        repeat (4) @(posedge clk);
        #1;
        chk("finish_b2b", {29'd0, idx_valid, busy, finish}, 32'd1);
        wait_drain(0, 50);

        // Throttled run: pairs held while ready is low
        rdy_mode = 1;
        launch(0);
        wait_drain(0, 100);

        // Abort after the second transfer, then replay from (1,1)
        rdy_mode = 0;
        launch(0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q[0].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs", {13'd0, idx_valid, busy, finish, idx_i, idx_j}, 32'd0);
        @(posedge clk); #1;
        chk("abort_quiet", {31'd0, idx_valid}, 32'd0);
        launch(0);
        chk("replay_pair", {16'd0, idx_i, idx_j}, {16'd0, 8'd1, 8'd1});
        wait_drain(0, 50);

        // start during EMIT ignored; start in DONE restarts
        rdy_mode = 1;
        launch(0);
        repeat (2) @(posedge clk);
        launch(0);
        wait_drain(0, 100);
        chk("done_finish", {31'd0, finish}, 32'd1);
        launch(0);
        chk("restart_finish_drop", {29'd0, idx_valid, busy, finish}, 32'd6);
        wait_drain(0, 100);

        // Empty outer loop: finish next cycle, no transfers
        @(posedge clk); #1;
        e_start = 1'b1;
        @(posedge clk); #1;
        e_start = 1'b0;
        chk("empty_finish", {29'd0, e_valid, e_busy, e_finish}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("empty_quiet", {29'd0, e_valid, e_busy, e_finish}, 32'd1);
        e_start = 1'b1;
        @(posedge clk); #1;
        e_start = 1'b0;
        chk("empty_restart", {29'd0, e_valid, e_busy, e_finish}, 32'd1);

        // Tall 3x1 loop under random backpressure
        rdy_mode = 2;
        launch(1);
        chk("tall_first", {16'd0, t_i, t_j}, {16'd0, 8'd2, 8'd0});
        wait_drain(1, 200);
        rdy_mode = 0;
        launch(1);
        wait_drain(1, 50);

        // Randomised runs with stray start pulses on the main instance
        for (int k = 0; k < 20; k++) begin
            rdy_mode = int'($urandom_range(0, 2));
            launch(0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                launch(0);
            end
            wait_drain(0, 200);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nested_loop_rev
`default_nettype wire
